// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer port arbiter: video FIFO write bursts vs display read bursts.
// Optional macro VIDEO_PRIORITY_EN: video wins every tie instead of round-robin.
module frame_buffer_arbiter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int BURST_LEN  = 8,
    parameter int ADDR_W     = 22
) (
    input  logic              rdclk,
    input  logic              nReset,
    input  logic              vidAvailable,
    output logic              vidRdreq,
    input  logic [15:0]       vidData,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              dispGrant,
    output logic [15:0]       dispData,
    output logic              dispValid,
    output logic              dispDone,
    output logic [ADDR_W-1:0] memAddr,
    output logic [15:0]       memWrData,
    output logic              memWrite,
    output logic              memRead,
    input  logic              memWait,
    input  logic [15:0]       memRdData,
    input  logic              memRdValid,
    output logic              frameDone
);

    localparam int FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);
    localparam logic [CW-1:0] BL_M1 = CW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_BURST,
        S_RD_CMD,
        S_RD_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_iss;
    logic [CW-1:0]     r_ret;
    logic              r_pend;
    logic              r_skid_full;
    logic [15:0]       r_skid;
    logic              r_last_disp;
    logic              r_disp_grant;
    logic              r_disp_valid;
    logic [15:0]       r_disp_data;
    logic              r_disp_done;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_in_rd;
    logic w_rd_ret;
    logic w_last_ret;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_wr_acc   = (r_state == S_WR_BURST) && r_skid_full && !memWait;
    assign w_rd_acc   = (r_state == S_RD_CMD) && !memWait;
    assign w_in_rd    = (r_state == S_RD_CMD) || (r_state == S_RD_DRAIN);
    assign w_rd_ret   = w_in_rd && memRdValid;
    assign w_last_ret = w_rd_ret && (r_ret == BL_M1);

    assign frameDone = w_wr_acc && (r_waddr == LAST_ADDR);
    assign dispGrant = r_disp_grant;
    assign dispValid = r_disp_valid;
    assign dispData  = r_disp_data;
    assign dispDone  = r_disp_done;

    // Next-state, grant decision and memory command outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        vidRdreq    = 1'b0;
        memWrite    = 1'b0;
        memRead     = 1'b0;
        memAddr     = '0;
        memWrData   = '0;
        unique case (r_state)
            S_IDLE: begin
`ifdef VIDEO_PRIORITY_EN
                w_grant_wr = vidAvailable;
`else
                w_grant_wr = vidAvailable && (!dispReq || r_last_disp);
`endif
                w_grant_rd = dispReq && !w_grant_wr;
                if (w_grant_wr)
                    w_state_nxt = S_WR_BURST;
                else if (w_grant_rd)
                    w_state_nxt = S_RD_CMD;
            end
            S_WR_BURST: begin
                // A pending FIFO word counts as skid occupancy.
                vidRdreq  = (r_iss < BL) && !r_pend &&
                            (!r_skid_full || w_wr_acc);
                memWrite  = r_skid_full;
                memAddr   = r_waddr;
                memWrData = r_skid;
                if (w_wr_acc && (r_cnt == BL_M1))
                    w_state_nxt = S_IDLE;
            end
            S_RD_CMD: begin
                memRead = 1'b1;
                memAddr = r_raddr + ADDR_W'(r_cnt);
                if (w_rd_acc && (r_cnt == BL_M1))
                    w_state_nxt = S_RD_DRAIN;
            end
            S_RD_DRAIN: begin
                if (w_last_ret)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, burst counters, skid and write address.
    always_ff @(posedge rdclk or negedge nReset) begin
        if (!nReset) begin
            r_state      <= S_IDLE;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_cnt        <= '0;
            r_iss        <= '0;
            r_ret        <= '0;
            r_pend       <= 1'b0;
            r_skid_full  <= 1'b0;
            r_skid       <= '0;
            r_disp_grant <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_disp_grant <= w_grant_rd;
            if (w_grant_rd)
                r_raddr <= dispAddr;
            if (w_wr_acc)
                r_waddr <= frameDone ? '0 : r_waddr + ADDR_W'(1);
            if (r_state == S_IDLE) begin
                r_cnt       <= '0;
                r_iss       <= '0;
                r_ret       <= '0;
                r_pend      <= 1'b0;
                r_skid_full <= 1'b0;
            end else begin
                r_pend <= vidRdreq;
                if (w_wr_acc || w_rd_acc)
                    r_cnt <= r_cnt + CW'(1);
                if (vidRdreq)
                    r_iss <= r_iss + CW'(1);
                if (w_rd_ret)
                    r_ret <= r_ret + CW'(1);
                if (r_pend) begin
                    r_skid      <= vidData;
                    r_skid_full <= 1'b1;
                end else if (w_wr_acc) begin
                    r_skid_full <= 1'b0;
                end
            end
        end
    end

    // Registered read-return path toward the display.
    always_ff @(posedge rdclk or negedge nReset) begin
        if (!nReset) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_disp_done  <= 1'b0;
        end else begin
            r_disp_valid <= w_rd_ret;
            r_disp_done  <= w_last_ret;
            if (w_rd_ret)
                r_disp_data <= memRdData;
        end
    end

`ifndef VIDEO_PRIORITY_EN
    // Round-robin memory of who was served last.
    always_ff @(posedge rdclk or negedge nReset) begin
        if (!nReset)
            r_last_disp <= 1'b1;
        else if (w_grant_wr)
            r_last_disp <= 1'b0;
        else if (w_grant_rd)
            r_last_disp <= 1'b1;
    end
`else
    assign r_last_disp = 1'b0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a 4x4 frame.
// Models a counting video FIFO and a fixed latency-3 memory.
module tb_frame_buffer_arbiter;

    localparam int AW = 22;

    logic          rdclk;
    logic          nReset;
    logic          vidAvailable;
    logic          vidRdreq;
    logic [15:0]   vidData;
    logic          dispReq;
    logic [AW-1:0] dispAddr;
    logic          dispGrant;
    logic [15:0]   dispData;
    logic          dispValid;
    logic          dispDone;
    logic [AW-1:0] memAddr;
    logic [15:0]   memWrData;
    logic          memWrite;
    logic          memRead;
    logic          memWait;
    logic [15:0]   memRdData;
    logic          memRdValid;
    logic          frameDone;

    frame_buffer_arbiter #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .BURST_LEN(8), .ADDR_W(AW)
    ) dut (
        .rdclk(rdclk), .nReset(nReset),
        .vidAvailable(vidAvailable), .vidRdreq(vidRdreq), .vidData(vidData),
        .dispReq(dispReq), .dispAddr(dispAddr), .dispGrant(dispGrant),
        .dispData(dispData), .dispValid(dispValid), .dispDone(dispDone),
        .memAddr(memAddr), .memWrData(memWrData), .memWrite(memWrite),
        .memRead(memRead), .memWait(memWait), .memRdData(memRdData),
        .memRdValid(memRdValid), .frameDone(frameDone)
    );

    int total = 0;
    int bad = 0;

    initial begin
        rdclk = 0;
        forever #5 rdclk = ~rdclk;
    end

    // memWait toggles every cycle while enabled
    logic tog_en = 0;
    logic tog = 0;
    always @(negedge rdclk) tog <= ~tog;
    assign memWait = tog_en & tog;

    // video FIFO: incrementing data one cycle after read request
    logic [15:0] fifo_cnt = 0;
    always @(posedge rdclk) begin
        vidData <= fifo_cnt;
        if (vidRdreq) fifo_cnt <= fifo_cnt + 16'd1;
    end

    // memory: read data = addr ^ 5A5A, latency 3
    logic [2:0]  pv = 0;
    logic [15:0] pd0 = 0, pd1 = 0, pd2 = 0;
    always @(posedge rdclk) begin
        pv  <= {pv[1:0], memRead && !memWait};
        pd0 <= memAddr[15:0] ^ 16'h5A5A;
        pd1 <= pd0;
        pd2 <= pd1;
    end
    assign memRdValid = pv[2];
    assign memRdData  = pd2;

    // monitor logs
    int wr_n = 0, rq_n = 0, fd_n = 0, fd_at = 0;
    int rd_n = 0, dv_n = 0, dd_n = 0, dd_at = 0;
    int both_bad = 0, stall_bad = 0;
    logic [AW-1:0] wr_addr [0:127];
    logic [15:0]   wr_data [0:127];
    logic [AW-1:0] rd_addr [0:127];
    logic [15:0]   dv_data [0:127];
    logic          hold = 0;
    logic [AW-1:0] h_addr = 0;
    logic [15:0]   h_data = 0;

    always @(posedge rdclk) begin
        if (memWrite && memRead) both_bad++;
        if (hold && (!memWrite || memAddr !== h_addr || memWrData !== h_data))
            stall_bad++;
        hold   = memWrite && memWait;
        h_addr = memAddr;
        h_data = memWrData;
        if (memWrite && !memWait) begin
            if (wr_n < 128) begin
                wr_addr[wr_n] = memAddr;
                wr_data[wr_n] = memWrData;
            end
            wr_n++;
            if (frameDone) fd_at = wr_n;
        end
        if (frameDone) fd_n++;
        if (vidRdreq) rq_n++;
        if (memRead && !memWait) begin
            if (rd_n < 128) rd_addr[rd_n] = memAddr;
            rd_n++;
        end
        if (dispValid) begin
            if (dv_n < 128) dv_data[dv_n] = dispData;
            dv_n++;
            if (dispDone) dd_at = dv_n;
        end
        if (dispDone) dd_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vid();
        @(negedge rdclk) vidAvailable = 1;
        @(negedge rdclk) vidAvailable = 0;
    endtask

    task automatic wait_wr(input int tgt);
        for (int k = 0; k < 300 && wr_n < tgt; k++) @(negedge rdclk);
        chk("wr_wait", 32'(wr_n >= tgt), 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge rdclk);
    endtask

    int wb, qb, rb, vb, lrq, sn;
    logic [3:0] seq;
    logic found;

    initial begin
        nReset = 0; vidAvailable = 0; dispReq = 0; dispAddr = '0;
        idle(2);
        // reset state
        chk("rst_rdreq", 32'(vidRdreq), 0);
        chk("rst_grant", 32'(dispGrant), 0);
        chk("rst_valid", 32'(dispValid), 0);
        chk("rst_done", 32'(dispDone), 0);
        chk("rst_wr", 32'(memWrite), 0);
        chk("rst_rd", 32'(memRead), 0);
        chk("rst_addr", 32'(memAddr), 0);
        chk("rst_wdata", 32'(memWrData), 0);
        chk("rst_frame", 32'(frameDone), 0);
        chk("rst_ddata", 32'(dispData), 0);
        @(negedge rdclk) nReset = 1;

        // one write burst, no stall
        wb = wr_n; qb = rq_n;
        pulse_vid();
        wait_wr(wb + 8);
        idle(4);
        chk("b1_rdreq", 32'(rq_n - qb), 8);
        for (int i = 0; i < 8; i++) begin
            chk("b1_addr", 32'(wr_addr[wb + i]), 32'(i));
            chk("b1_data", 32'(wr_data[wb + i]), 32'(i));
        end
        chk("b1_idle", 32'(memWrite), 0);
        chk("b1_nofd", 32'(fd_n), 0);

        // stalled write burst, wraps 15 -> 0
        tog_en = 1;
        wb = wr_n; qb = rq_n;
        pulse_vid();
        wait_wr(wb + 8);
        idle(4);
        tog_en = 0;
        chk("b2_rdreq", 32'(rq_n - qb), 8);
        for (int i = 0; i < 8; i++) begin
            chk("b2_addr", 32'(wr_addr[wb + i]), 32'(8 + i));
            chk("b2_data", 32'(wr_data[wb + i]), 32'(8 + i));
        end
        chk("b2_stable", 32'(stall_bad), 0);
        chk("fd_count", 32'(fd_n), 1);
        chk("fd_at", 32'(fd_at), 16);

        // read burst at 0x100
        rb = rd_n; vb = dv_n;
        @(negedge rdclk) begin dispReq = 1; dispAddr = 22'h100; end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge rdclk);
            found = dispGrant;
        end
        chk("rd_grant", 32'(found), 1);
        dispReq = 0;
        dispAddr = 22'h3FF;
        @(negedge rdclk);
        chk("rd_gpulse", 32'(dispGrant), 0);
        for (int k = 0; k < 60 && dv_n < vb + 8; k++) @(negedge rdclk);
        idle(3);
        chk("rd_cmds", 32'(rd_n - rb), 8);
        chk("rd_valids", 32'(dv_n - vb), 8);
        for (int i = 0; i < 8; i++) begin
            chk("rd_addr", 32'(rd_addr[rb + i]), 32'(32'h100 + i));
            chk("rd_data", 32'(dv_data[vb + i]),
                32'(16'(32'h100 + i) ^ 16'h5A5A));
        end
        chk("rd_done_n", 32'(dd_n), 1);
        chk("rd_done_at", 32'(dd_at - vb), 8);

        // reset in the middle of a write burst
        wb = wr_n;
        pulse_vid();
        wait_wr(wb + 3);
        nReset = 0;
        #1;
        chk("mr_rdreq", 32'(vidRdreq), 0);
        chk("mr_wr", 32'(memWrite), 0);
        chk("mr_addr", 32'(memAddr), 0);
        chk("mr_wdata", 32'(memWrData), 0);
        @(negedge rdclk) nReset = 1;
        wb = wr_n;
        pulse_vid();
        wait_wr(wb + 8);
        chk("mr_first", 32'(wr_addr[wb]), 0);
        chk("mr_last", 32'(wr_addr[wb + 7]), 7);
        idle(4);

        // both requesting: arbitration order
        nReset = 0;
        @(negedge rdclk) nReset = 1;
        dispAddr = 22'h200;
        dispReq = 1;
        @(negedge rdclk);
        lrq = 0; sn = 0; seq = '0;
        for (int k = 0; k < 600 && sn < 4; k++) begin
            if (dispGrant) begin
                seq[sn] = 1'b0;
                sn++;
            end else if (vidRdreq) begin
                if (lrq % 8 == 0) begin
                    seq[sn] = 1'b1;
                    sn++;
                end
                lrq++;
            end
            vidAvailable = 1;
            @(negedge rdclk);
        end
        chk("arb_count", 32'(sn), 4);
        chk("arb_g0", 32'(seq[0]), 0);
        chk("arb_g1", 32'(seq[1]), 1);
`ifdef VIDEO_PRIORITY_EN
        chk("arb_g2", 32'(seq[2]), 1);
`else
        chk("arb_g2", 32'(seq[2]), 0);
`endif
        chk("arb_g3", 32'(seq[3]), 1);
        dispReq = 0;
        vidAvailable = 0;
        idle(80);
        chk("end_wr", 32'(memWrite), 0);
        chk("end_rd", 32'(memRead), 0);
        chk("excl", 32'(both_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
